// File: rtl/avg_frame_ctrl.sv
// avg_frame_ctrl
//   Sequencer for the vertical-average datapath (frame buffer RAM plus a
//   two-row averager). Loads one ROWS x COLS frame row-major through an
//   in_valid/in_ready handshake, then issues one read pair per cycle for every
//   vertically adjacent pixel pair (row r, row r+1). It also generates the
//   averager load strobe, the result valid, the result coordinates and an
//   end-of-frame pulse, and then re-arms for the next frame.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_LOAD    | accepting pixels; wcnt is the write address
//   S_COMPUTE | issuing read pairs (rcnt, rcnt+COLS), one per cycle
//   S_DRAIN   | two cycles that let the last reads finish the pipeline
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   in_valid_i     input pixel present this cycle
//   in_ready_o     controller accepts a pixel this cycle (S_LOAD)
//   mem_we_o       buffer write enable
//   mem_waddr_o    buffer write address
//   rd_en_o        buffer read enable; data returns the next cycle
//   mem_raddr_a_o  upper-row pixel address
//   mem_raddr_b_o  lower-row pixel address
//   dp_load_o      averager captures (a+b)>>1 this cycle
//   valid_o        averager output register holds a new result
//   out_row_o      row index of the result on valid_o
//   out_col_o      column index of the result on valid_o
//   busy_o         high in S_COMPUTE and S_DRAIN
//   done_o         one-cycle pulse with the last valid_o of a frame
module avg_frame_ctrl #(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 16,
  parameter int unsigned AW   = 7,
  localparam int unsigned RW  = (ROWS > 2) ? $clog2(ROWS - 1) : 1,
  localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic          rd_en_o,
  output logic [AW-1:0] mem_raddr_a_o,
  output logic [AW-1:0] mem_raddr_b_o,
  output logic          dp_load_o,
  output logic          valid_o,
  output logic [RW-1:0] out_row_o,
  output logic [CW-1:0] out_col_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [AW-1:0] WLAST    = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0] RLAST    = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] COLS_AW  = AW'(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 2);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  if (ROWS < 2 || (2 ** AW) < (ROWS * COLS)) begin : g_bad_param
    $error("avg_frame_ctrl: need ROWS >= 2 and 2**AW >= ROWS*COLS");
  end

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] wcnt_q;
  logic [AW-1:0] rcnt_q;
  // Row/column of rcnt kept as counters so no divider is needed.
  logic [RW-1:0] rrow_q;
  logic [CW-1:0] rcol_q;
  logic          drain_tmr_q;
  // Stage 1 of the result pipeline (buffer data valid).
  logic          dp_load_q;
  logic [RW-1:0] row1_q;
  logic [CW-1:0] col1_q;
  // Stage 2 (average register valid).
  logic          valid_q;
  logic [RW-1:0] out_row_q;
  logic [CW-1:0] out_col_q;
  logic          done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_LOAD;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      rrow_q      <= '0;
      rcol_q      <= '0;
      drain_tmr_q <= 1'b0;
      dp_load_q   <= 1'b0;
      row1_q      <= '0;
      col1_q      <= '0;
      valid_q     <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      dp_load_q <= (state_q == S_COMPUTE);
      row1_q    <= rrow_q;
      col1_q    <= rcol_q;
      valid_q   <= dp_load_q;
      out_row_q <= row1_q;
      out_col_q <= col1_q;
      // Registered one stage early so it lines up with the last valid.
      done_q    <= dp_load_q && (row1_q == ROW_LAST) && (col1_q == COL_LAST);

      unique case (state_q)
        S_LOAD: begin
          if (in_valid_i) begin
            if (wcnt_q == WLAST) begin
              wcnt_q  <= '0;
              state_q <= S_COMPUTE;
            end else begin
              wcnt_q <= wcnt_q + AW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (rcnt_q == RLAST) begin
            rcnt_q      <= '0;
            rrow_q      <= '0;
            rcol_q      <= '0;
            drain_tmr_q <= 1'b1;
            state_q     <= S_DRAIN;
          end else begin
            rcnt_q <= rcnt_q + AW'(1);
            if (rcol_q == COL_LAST) begin
              rcol_q <= '0;
              rrow_q <= rrow_q + RW'(1);
            end else begin
              rcol_q <= rcol_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_tmr_q == 1'b0) begin
            state_q <= S_LOAD;
          end else begin
            drain_tmr_q <= drain_tmr_q - 1'b1;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready_o    = (state_q == S_LOAD);
  assign mem_we_o      = in_ready_o && in_valid_i;
  assign mem_waddr_o   = wcnt_q;
  assign rd_en_o       = (state_q == S_COMPUTE);
  assign mem_raddr_a_o = rcnt_q;
  assign mem_raddr_b_o = rcnt_q + COLS_AW;
  assign dp_load_o     = dp_load_q;
  assign valid_o       = valid_q;
  assign out_row_o     = out_row_q;
  assign out_col_o     = out_col_q;
  assign busy_o        = (state_q != S_LOAD);
  assign done_o        = done_q;

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Directed bench for avg_frame_ctrl with a behavioural frame buffer and
// averager attached, checking a table of per-cycle expectations plus
// hand-written sequences for gaps, reset during COMPUTE and back-to-back frames.
module tb_avg_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic       rd_en;
  logic [6:0] raddr_a;
  logic [6:0] raddr_b;
  logic       dp_load;
  logic       valid;
  logic [3:0] out_row;
  logic [2:0] out_col;
  logic       busy;
  logic       done;

  avg_frame_ctrl #(.COLS(8), .ROWS(16), .AW(7)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .mem_we_o     (mem_we),
    .mem_waddr_o  (mem_waddr),
    .rd_en_o      (rd_en),
    .mem_raddr_a_o(raddr_a),
    .mem_raddr_b_o(raddr_b),
    .dp_load_o    (dp_load),
    .valid_o      (valid),
    .out_row_o    (out_row),
    .out_col_o    (out_col),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel value written at each buffer address.
  function automatic logic [7:0] pix(input logic [6:0] a);
    int v;
    if (a == 7'd0) return 8'd200;
    if (a == 7'd8) return 8'd101;
    v = int'(a) * 3 + 7;
    return 8'(v);
  endfunction

  // Behavioural frame buffer and averager.
  logic [7:0] mem [0:127];
  logic [7:0] da, db, avg;
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= pix(mem_waddr);
    if (rd_en) begin
      da <= mem[raddr_a];
      db <= mem[raddr_b];
    end
    if (dp_load) avg <= 8'((9'(da) + 9'(db)) >> 1);
  end

  typedef struct {
    int         cyc;
    logic       ir, we;
    logic [6:0] wa;
    logic       rd;
    logic [6:0] ra, rb;
    logic       dl, v;
    logic [3:0] row;
    logic [2:0] col;
    logic       bsy, dn;
  } vec_t;

  function automatic vec_t mk(int c, int ir, int we, int wa, int rd, int ra, int rb,
                              int dl, int v, int row, int col, int bsy, int dn);
    vec_t r;
    r.cyc = c;     r.ir = 1'(ir);   r.we = 1'(we);   r.wa = 7'(wa);
    r.rd = 1'(rd); r.ra = 7'(ra);   r.rb = 7'(rb);   r.dl = 1'(dl);
    r.v = 1'(v);   r.row = 4'(row); r.col = 3'(col); r.bsy = 1'(bsy);
    r.dn = 1'(dn);
    return r;
  endfunction

  function automatic logic [63:0] pack(vec_t r);
    return {29'd0, r.ir, r.we, r.wa, r.rd, r.ra, r.rb, r.dl, r.v, r.row, r.col, r.bsy, r.dn};
  endfunction

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t e);
    vec_t a;
    a = mk(e.cyc, int'(in_ready), int'(mem_we), int'(mem_waddr), int'(rd_en),
           int'(raddr_a), int'(raddr_b), int'(dp_load), int'(valid),
           int'(out_row), int'(out_col), int'(busy), int'(done));
    n_vec++;
    if (pack(a) != pack(e)) begin
      n_bad++;
      $display("FAIL vec@cyc%0d {ir,we,wa,rd,ra,rb,dl,v,row,col,busy,done}: got %h expected %h",
               e.cyc, pack(a), pack(e));
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  int iss, res, vcount, first_v, ndone, wecount;
  int done_c [2];

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;

    //            cyc ir we  wa rd  ra  rb dl v row col bsy dn
    vecs[0]  = mk(  0, 1, 1,   0, 0,   0,   8, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(  1, 1, 1,   1, 0,   0,   8, 0, 0,  0, 0, 0, 0);
    vecs[2]  = mk( 64, 1, 1,  64, 0,   0,   8, 0, 0,  0, 0, 0, 0);
    vecs[3]  = mk(127, 1, 1, 127, 0,   0,   8, 0, 0,  0, 0, 0, 0);
    vecs[4]  = mk(128, 0, 0,   0, 1,   0,   8, 0, 0,  0, 0, 1, 0);
    vecs[5]  = mk(129, 0, 0,   0, 1,   1,   9, 1, 0,  0, 0, 1, 0);
    vecs[6]  = mk(130, 0, 0,   0, 1,   2,  10, 1, 1,  0, 0, 1, 0);
    vecs[7]  = mk(136, 0, 0,   0, 1,   8,  16, 1, 1,  0, 6, 1, 0);
    vecs[8]  = mk(138, 0, 0,   0, 1,  10,  18, 1, 1,  1, 0, 1, 0);
    vecs[9]  = mk(200, 0, 0,   0, 1,  72,  80, 1, 1,  8, 6, 1, 0);
    vecs[10] = mk(247, 0, 0,   0, 1, 119, 127, 1, 1, 14, 5, 1, 0);
    vecs[11] = mk(248, 0, 0,   0, 0,   0,   8, 1, 1, 14, 6, 1, 0);
    vecs[12] = mk(249, 0, 0,   0, 0,   0,   8, 0, 1, 14, 7, 1, 1);
    vecs[13] = mk(250, 1, 1,   0, 0,   0,   8, 0, 0,  0, 0, 0, 0);
    vecs[14] = mk(251, 1, 1,   1, 0,   0,   8, 0, 0,  0, 0, 0, 0);
    vecs[15] = mk(499, 0, 0,   0, 0,   0,   8, 0, 1, 14, 7, 1, 1);
    vecs[16] = mk(500, 1, 1,   0, 0,   0,   8, 0, 0,  0, 0, 0, 0);

    // Continuous in_valid: two back-to-back frames plus the start of a third.
    do_reset();
    iss = 0; res = 0; vcount = 0; first_v = -1; ndone = 0; wecount = 0;
    done_c[0] = -1; done_c[1] = -1;
    for (int c = 0; c < 506; c++) begin
      tick();
      reset    = 1'b0;
      in_valid = 1'b1;
      #1;
      for (int i = 0; i < NV; i++)
        if (vecs[i].cyc == c) chk_vec(vecs[i]);
      if (rd_en) begin
        chk("issue_a", int'(raddr_a), iss);
        chk("issue_b", int'(raddr_b), iss + 8);
        iss = (iss == 119) ? 0 : iss + 1;
      end
      if (valid) begin
        chk("res_row", int'(out_row), res / 8);
        chk("res_col", int'(out_col), res % 8);
        chk("res_avg", int'(avg), (int'(pix(7'(res))) + int'(pix(7'(res + 8)))) / 2);
        if (c == 130 || c == 380) chk("avg_first_pair", int'(avg), 150);
        res = (res == 119) ? 0 : res + 1;
        if (c < 250) vcount++;
        if (first_v < 0) first_v = c;
      end
      if (done) begin
        if (ndone < 2) done_c[ndone] = c;
        ndone++;
      end
      if (mem_we && c < 250) wecount++;
    end
    chk("frame1_writes", wecount, 128);
    chk("frame1_valids", vcount, 120);
    chk("first_valid_cyc", first_v, 130);
    chk("done_count", ndone, 2);
    chk("done_spacing", done_c[1] - done_c[0], 250);

    // Reset on the 60th COMPUTE cycle.
    do_reset();
    for (int c = 0; c < 187; c++) begin
      tick();
      reset    = 1'b0;
      in_valid = 1'b1;
    end
    tick();
    reset = 1'b1;
    #1;
    chk("pre_reset_rd_en", int'(rd_en), 1);
    chk("pre_reset_raddr", int'(raddr_a), 59);
    tick();
    reset    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_dp_load", int'(dp_load), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(mem_we), 1);
    chk("rst_waddr", int'(mem_waddr), 0);
    tick();
    #1;
    chk("rst_waddr_next", int'(mem_waddr), 1);

    // in_valid toggled 1,0,1,0: 128th accept lands on cycle 254.
    do_reset();
    for (int c = 0; c < 259; c++) begin
      tick();
      reset    = 1'b0;
      in_valid = (c % 2 == 0);
      #1;
      if (c <= 254) begin
        chk("tog_waddr", int'(mem_waddr), (c + 1) / 2);
        chk("tog_we", int'(mem_we), (c % 2 == 0) ? 1 : 0);
        chk("tog_in_ready", int'(in_ready), 1);
      end
      if (c == 255) begin
        chk("tog_compute_rd", int'(rd_en), 1);
        chk("tog_compute_ir", int'(in_ready), 0);
        chk("tog_compute_ra", int'(raddr_a), 0);
        chk("tog_compute_rb", int'(raddr_b), 8);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
